// File: rtl/rgb_arbiter.sv
// rgb_arbiter: round-robin owner of the shared RGB LED with minimum hold and
// maximum-ownership timeout; outputs are decoded live from the registered owner.
module rgb_arbiter #(
  parameter int N_REQ         = 3,
  parameter int HOLD_TICKS    = 1000,
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   rgb_in,
  output logic [N_REQ-1:0]     grant,
  output logic [2:0]           rgb,
  output logic                 busy
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] TO_M1   = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_TICKS);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ERROR} state_t;
  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d, ptr_q, ptr_d, pick;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  owner_oh;
  logic [2:0]        rgb_sel;
  logic              found, owner_req, others, release_now;
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = OW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end
  always_comb begin
    owner_oh = '0;
    rgb_sel  = 3'b000;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        owner_oh[i] = 1'b1;
        rgb_sel     = rgb_in[3*i +: 3];
      end
    end
  end
  assign owner_req   = |(req & owner_oh);
  assign others      = |(req & ~owner_oh);
  assign release_now = (cnt_q >= HOLD_M1 && !owner_req) || (cnt_q >= TO_M1 && others);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          owner_d = pick;
          cnt_d   = '0;
          ptr_d   = (pick == OW'(N_REQ - 1)) ? '0 : pick + 1'b1;
        end
      end
      S_GRANT: begin
        cnt_d   = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
        // an owner index with no matching requester can only come from corruption
        state_d = !(|owner_oh) ? S_ERROR : release_now ? S_IDLE : S_GRANT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy  = (state_q == S_GRANT);
  assign grant = busy ? owner_oh : '0;
  assign rgb   = busy ? rgb_sel : 3'b000;
endmodule

// File: tb/tb_rgb_arbiter.sv
// tb_rgb_arbiter: directed scenarios plus random traffic, every cycle compared
// against a cycle-level behavioural model of the arbitration rules.
module tb_rgb_arbiter;
  localparam int N = 3;
  localparam int H = 4;
  localparam int T = 10;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] rgb_in = 9'b011_101_110;
  logic [N-1:0]   grant;
  logic [2:0]     rgb;
  logic           busy;
  int errs = 0, checks = 0;
  int m_own = 0, m_cnt = 0, m_ptr = 0;
  bit m_busy = 0;
  rgb_arbiter #(.N_REQ(N), .HOLD_TICKS(H), .TIMEOUT_TICKS(T)) dut (
    .clk(clk), .rst(rst), .req(req), .rgb_in(rgb_in),
    .grant(grant), .rgb(rgb), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic mreset;
    m_own = 0; m_cnt = 0; m_ptr = 0; m_busy = 0;
  endtask
  task automatic mstep;
    int j;
    bit rel;
    if (m_busy) begin
      rel = (m_cnt >= H - 1 && !req[m_own]) ||
            (m_cnt >= T - 1 && (req & ~(N'(1) << m_own)) != 0);
      if (m_cnt < T) m_cnt++;
      if (rel) m_busy = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (req[j]) begin
          m_own = j; m_busy = 1; m_cnt = 0; m_ptr = (j + 1) % N;
          break;
        end
      end
    end
  endtask
  task automatic cmp(input string tag);
    logic [2:0] col;
    col = rgb_in[3*m_own +: 3];
    chk({tag, ".grant"}, 32'(grant), m_busy ? 32'(1) << m_own : 32'd0);
    chk({tag, ".rgb"}, 32'(rgb), m_busy ? 32'(col) : 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) mreset(); else mstep();
    #1;
    cmp(tag);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    mreset();
    #1;
    cmp("rst");
    tick("rst");
    rst = 1'b0;
  endtask
  task automatic drain;
    req = '0;
    for (int i = 0; i < 40 && busy; i++) tick("drain");
    chk("drain_idle", 32'(busy), 32'd0);
  endtask
  int n;
  logic [N-1:0] g;
  initial begin
    // reset with all requests pending
    req = 3'b111;
    #1;
    cmp("reset0");
    for (int i = 0; i < 3; i++) tick("reset_hold");
    rst = 1'b0;
    tick("reset_rel");
    chk("reset_first_grant", 32'(grant), 32'b001);
    drain();
    // single pulse from requester 1
    do_reset();
    tick("pulse_pre");
    req = 3'b010;
    tick("pulse");
    chk("pulse_grant", 32'(grant), 32'b010);
    chk("pulse_rgb", 32'(rgb), 32'b101);
    req = '0;
    n = 1;
    for (int i = 0; i < 20 && grant == 3'b010; i++) begin
      tick("pulse");
      if (grant == 3'b010) n++;
    end
    chk("pulse_len", 32'(n), 32'd4);
    chk("pulse_blank_rgb", 32'(rgb), 32'd0);
    chk("pulse_blank_busy", 32'(busy), 32'd0);
    // round robin, each owner drops its request on its first cycle
    do_reset();
    req = 3'b111;
    tick("rr");
    for (int r = 0; r < 4; r++) begin
      g = grant;
      chk("rr_order", 32'(g), 32'(1) << (r % 3));
      req = req & ~g;
      n = 1;
      for (int i = 0; i < 20 && grant == g; i++) begin
        tick("rr");
        if (grant == g) n++;
      end
      chk("rr_len", 32'(n), 32'd4);
      chk("rr_blank", 32'(busy), 32'd0);
      req = 3'b111;
      tick("rr");
    end
    drain();
    // preemption of a persistent owner by requester 2
    do_reset();
    req = 3'b001;
    tick("pre");
    tick("pre");
    req = 3'b101;
    n = 2;
    for (int i = 0; i < 30 && grant == 3'b001; i++) begin
      tick("pre");
      if (grant == 3'b001) n++;
    end
    chk("pre_len", 32'(n), 32'd10);
    chk("pre_blank", 32'(busy), 32'd0);
    tick("pre");
    chk("pre_next", 32'(grant), 32'b100);
    drain();
    // lone owner holds indefinitely with saturating counter
    do_reset();
    req = 3'b001;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick("lone");
      if (grant == 3'b001) n++;
    end
    chk("lone_len", 32'(n), 32'd100);
    chk("lone_cnt_sat", 32'(dut.cnt_q), 32'(T));
    req = '0;
    tick("lone_rel");
    chk("lone_rel_busy", 32'(busy), 32'd0);
    // asynchronous reset in the middle of a grant to requester 2
    do_reset();
    rgb_in = 9'b111_101_110;
    req = 3'b100;
    tick("ar");
    tick("ar");
    tick("ar");
    chk("ar_owner", 32'(grant), 32'b100);
    #2;
    rst = 1'b1;
    mreset();
    #1;
    chk("ar_grant0", 32'(grant), 32'd0);
    chk("ar_rgb0", 32'(rgb), 32'd0);
    req = 3'b110;
    tick("ar_hold");
    rst = 1'b0;
    tick("ar_rel");
    chk("ar_first", 32'(grant), 32'b010);
    // random traffic with live colour changes and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      rgb_in = 9'($urandom);
      #1;
      cmp("rnd_live");
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        mreset();
        #1;
        cmp("rnd_arst");
        tick("rnd_arst");
        rst = 1'b0;
      end
      tick("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rgb_arbiter.md
# rgb_arbiter

Shares the single on-board RGB LED between several independent requesters, such as the button-driven light sequencer, an error indicator and a heartbeat. Each requester presents a 3-bit colour and a request line. The block grants the LED to one requester at a time and drives that requester's colour out. It uses round-robin fairness, a minimum hold time and a maximum-ownership timeout. It sits between the colour-producing FSMs and the top-level `rgb` pins.

## Interface
- `N_REQ`, default 3: number of requesters; legal range 2..8.
- `HOLD_TICKS`, default 1000: minimum number of cycles a grant is held; must be ≥1.
- `TIMEOUT_TICKS`, default 50000: maximum number of cycles a grant is held while another requester waits; must be ≥ `HOLD_TICKS`.
- `clk`, input, 1: system clock; the block has one clock domain.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, `N_REQ`: per-requester request, level-sensitive, synchronous to `clk`.
- `rgb_in`, input, `3*N_REQ`: colours; requester i occupies bits `[3*i+2:3*i]`.
- `grant`, output, `N_REQ`: one-hot owner indication; all zeros when there is no owner.
- `rgb`, output, 3: colour driven to the LED.
- `busy`, output, 1: 1 while in `S_GRANT`.

## Operation
- States:
  - `S_IDLE`: no owner.
  - `S_GRANT`: one owner.
  - `S_ERROR`: any illegal encoding.
  - On reset, and from `S_ERROR` on the next edge, the state is `S_IDLE`.
- Registers:
  - `state`.
  - `owner` index, `$clog2(N_REQ)` bits.
  - `ptr` (round-robin start), same width.
  - `cnt`: `$clog2(TIMEOUT_TICKS+1)` bits, saturating at `TIMEOUT_TICKS`.
- Arbitration in `S_IDLE` only:
  - If any `req` bit is set, search from `ptr` upward with wrap to find the first set bit.
  - Load that index into `owner`, clear `cnt`, and go to `S_GRANT`.
  - Load `ptr` with `owner+1`, wrapping from `N_REQ-1` to 0.
- In `S_GRANT`, `cnt` increments every cycle; the first cycle in `S_GRANT` has `cnt`=0.
- Release, evaluated each `S_GRANT` cycle; either condition sends the next state to `S_IDLE`:
  - Voluntary: `cnt` ≥ `HOLD_TICKS-1` and `req[owner]`=0.
  - Preempt: `cnt` ≥ `TIMEOUT_TICKS-1` and some `req[j]`=1 with j≠`owner`.
- Behaviour inside a grant:
  - Dropping `req[owner]` before the hold time expires does not release the grant; the owner's colour continues to be shown.
  - A lone owner that keeps `req` asserted holds the LED indefinitely; `cnt` saturates and never wraps.
- Outputs, all combinational from registered state:
  - `grant` = one-hot of `owner` in `S_GRANT`, else 0.
  - `rgb` = the `rgb_in` slice of `owner` in `S_GRANT`, passed through live, else 3'b000.
  - `busy` = (`state` == `S_GRANT`).
- Reset values: `grant`=0, `rgb`=3'b000, `busy`=0, `ptr`=0, `owner`=0, `cnt`=0.

## Timing
- Grant latency: a `req` sampled high in `S_IDLE` at edge k produces `grant` and `rgb` valid from edge k, i.e. visible in cycle k+1.
- Grant length: minimum `HOLD_TICKS` cycles. With a competitor waiting, maximum `TIMEOUT_TICKS` cycles.
- Release gap: after any release the LED shows 000 for exactly one cycle in `S_IDLE` before the next grant. This blank cycle is mandatory.
- Back-to-back service with all requesters asserted: the grant order is 0,1,...,`N_REQ-1`,0,... with no requester skipped.
- Simultaneous events:
  - A competitor arriving on the same cycle the owner voluntarily releases does not matter; the release is the same either way.
  - If both release conditions hold at once, the result is a single release.
- Asynchronous reset mid-grant:
  - `grant`, `rgb` and `busy` go to 0 immediately, without waiting for a clock edge.
  - After reset deasserts, arbitration restarts with `ptr`=0.
- `rgb_in` changes from the owner appear on `rgb` in the same cycle, with no register stage.

## Test plan
Bench parameters: `N_REQ`=3, `HOLD_TICKS`=4, `TIMEOUT_TICKS`=10.
- Reset: assert `rst` with `req`=3'b111 -> `grant`=000, `rgb`=000, `busy`=0 throughout reset. On the first edge after release, `grant`=001.
- Single pulse: `req[1]` high for 1 cycle, `rgb_in[5:3]`=3'b101 -> `grant`=010 and `rgb`=101 for exactly 4 cycles. Then `rgb`=000 and `busy`=0.
- Round-robin: `req`=3'b111 held, each requester dropping its `req` on its first granted cycle -> grants 001, 010, 100, 001. Each grant lasts 4 cycles, separated by one blank cycle.
- Preemption: `req[0]` held continuously, `req[2]` raised on the 2nd grant cycle -> requester 0 is granted for 10 cycles, then 1 blank cycle, then `grant`=100.
- Lone owner: `req[0]` held for 100 cycles with no competitor -> `grant`=001 for all 100 cycles and `cnt` saturated at 10. Dropping `req[0]` releases on the next edge.
- Async reset mid-grant: assert `rst` between edges on the 3rd cycle of a grant to requester 2 -> `rgb`=000 and `grant`=000 immediately. After release with `req`=3'b110, the first grant is 010.
